serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_adder.sv | 123 ++++++++++++
 tb/tb_serial_adder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle of the bit-serial adder/subtractor.
// The master drives the operands and start; the slave returns the registered results.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic [WIDTH-1:0] Sum;
    logic             Carry;
    logic             Overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B, Cin, Sub,
        input  Sum, Carry, Overflow, busy, done
    );

    modport slave (
        input  start, A, B, Cin, Sub,
        output Sum, Carry, Overflow, busy, done
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one operand bit per clock, LSB first, WIDTH cycles per result.
// Subtraction reuses the adder as A + ~B + ~Cin; outputs hold until the next completion.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clock,
    input  logic           reset_n,
    serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic             accept_s;
    logic             sum_bit_s;
    logic             maj_s;

    // DONE also accepts start so that a held start yields one result every WIDTH+1 cycles.
    assign accept_s  = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign sum_bit_s = a_q[0] ^ b_q[0] ^ carry_q;
    assign maj_s     = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    // Next-state, datapath shifting and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_d = RUN;
                    a_d     = bus.A;
                    b_d     = bus.B ^ {WIDTH{bus.Sub}};
                    carry_d = bus.Cin ^ bus.Sub;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                res_d   = {sum_bit_s, res_q[WIDTH-1:1]};
                carry_d = maj_s;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_q here is the carry into the MSB, maj_s the carry out of it
                    state_d = DONE;
                    done_d  = 1'b1;
                    sum_d   = {sum_bit_s, res_q[WIDTH-1:1]};
                    cout_d  = maj_s;
                    ovf_d   = carry_q ^ maj_s;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.Sum      = sum_q;
    assign bus.Carry    = cout_q;
    assign bus.Overflow = ovf_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): expected results are queued at each
// acceptance and popped when done is seen; outputs are sampled on the falling edge.
module tb_serial_adder;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;
    logic [W+1:0] sb[$];

    serial_adder_if #(.WIDTH(W)) sa_if ();

    serial_adder #(.WIDTH(W)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (sa_if)
    );

    always #5 clk = ~clk;

    // Reference: returns {carry, overflow, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W-1:0] bb;
        logic         c;
        logic [W:0]   full;
        logic         ovf;
        bb   = sub ? ~b : b;
        c    = sub ? ~cin : cin;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {full[W], ovf, full[W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag);
        logic [W+1:0] e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_sum"},   {56'd0, sa_if.Sum}, {56'd0, e[W-1:0]});
            check({tag, "_carry"}, {63'd0, sa_if.Carry}, {63'd0, e[W+1]});
            check({tag, "_ovf"},   {63'd0, sa_if.Overflow}, {63'd0, e[W]});
        end else begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end
    endtask

    // Caller is at a falling edge; one operation with a single-cycle start.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input string tag);
        int           busy_cnt;
        int           done_at;
        logic [W-1:0] held;
        busy_cnt = 0;
        done_at  = 0;
        held     = sa_if.Sum;
        sa_if.A = a; sa_if.B = b; sa_if.Cin = cin; sa_if.Sub = sub; sa_if.start = 1'b1;
        sb.push_back(model(a, b, cin, sub));
        @(posedge clk); @(negedge clk);
        sa_if.start = 1'b0;
        sa_if.A = ~a; sa_if.B = ~b; sa_if.Cin = ~cin; sa_if.Sub = ~sub;
        check({tag, "_busy_t0"}, {63'd0, sa_if.busy}, 64'd0);
        for (int k = 1; k <= 12 && done_at == 0; k++) begin
            @(posedge clk); @(negedge clk);
            if (sa_if.busy) busy_cnt++;
            if (sa_if.done) done_at = k;
            else check({tag, "_sum_hold"}, {56'd0, sa_if.Sum}, {56'd0, held});
        end
        check({tag, "_latency"}, 64'(done_at), 64'd8);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd7);
        if (done_at != 0) check_result(tag);
        else if (sb.size() > 0) void'(sb.pop_front());
        @(posedge clk); @(negedge clk);
        check({tag, "_done_pulse"}, {63'd0, sa_if.done}, 64'd0);
    endtask

    initial begin
        int           done_cnt;
        int           first_done;
        int           second_done;
        logic [W+1:0] op1;
        clk = 1'b0;
        rst_n = 1'b1;
        vectors = 0;
        errors = 0;
        sa_if.start = 1'b0; sa_if.A = '0; sa_if.B = '0; sa_if.Cin = 1'b0; sa_if.Sub = 1'b0;

        // Reset asserted between edges must clear outputs immediately.
        #2 rst_n = 1'b0;
        #1;
        check("rst_sum",  {56'd0, sa_if.Sum}, 64'd0);
        check("rst_carry", {63'd0, sa_if.Carry}, 64'd0);
        check("rst_ovf",  {63'd0, sa_if.Overflow}, 64'd0);
        check("rst_busy", {63'd0, sa_if.busy}, 64'd0);
        check("rst_done", {63'd0, sa_if.done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'h0F, 8'h01, 1'b0, 1'b0, "add_0f_01");
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, "add_wrap");
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, "add_ovf");
        do_op(8'h05, 8'h07, 1'b0, 1'b1, "sub_neg");
        do_op(8'h80, 8'h01, 1'b1, 1'b1, "sub_ovf_bin");
        do_op(8'hC3, 8'h5A, 1'b1, 1'b0, "add_cin");

        // Held start: operands change mid-RUN; second op takes the values at its own acceptance.
        done_cnt = 0; first_done = 0; second_done = 0;
        op1 = model(8'h3C, 8'h0A, 1'b1, 1'b0);
        sa_if.A = 8'h3C; sa_if.B = 8'h0A; sa_if.Cin = 1'b1; sa_if.Sub = 1'b0; sa_if.start = 1'b1;
        sb.push_back(op1);
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); @(negedge clk);
            if (sa_if.done) begin
                done_cnt++;
                if (done_cnt == 1) first_done = e;
                else if (done_cnt == 2) second_done = e;
                check_result("held");
            end
            if (e >= 10 && e <= 17)
                check("held_sum_hold", {56'd0, sa_if.Sum}, {56'd0, op1[W-1:0]});
            if (e == 1) begin
                sa_if.A = 8'h10; sa_if.B = 8'h20; sa_if.Cin = 1'b0; sa_if.Sub = 1'b1;
            end
            if (e == 9) sb.push_back(model(8'h10, 8'h20, 1'b0, 1'b1));
            if (e == 10) begin
                sa_if.A = 8'hEE; sa_if.B = 8'h99; sa_if.Cin = 1'b1; sa_if.Sub = 1'b0;
            end
            if (e == 18) sa_if.start = 1'b0;
        end
        check("held_done_count", 64'(done_cnt), 64'd2);
        check("held_first_done", 64'(first_done), 64'd9);
        check("held_spacing", 64'(second_done - first_done), 64'd9);

        // Reset in the 4th RUN cycle aborts the operation.
        sa_if.A = 8'hAA; sa_if.B = 8'h55; sa_if.Cin = 1'b0; sa_if.Sub = 1'b0; sa_if.start = 1'b1;
        @(posedge clk); @(negedge clk);
        sa_if.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("abort_busy_before", {63'd0, sa_if.busy}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, sa_if.busy}, 64'd0);
        check("abort_sum",  {56'd0, sa_if.Sum}, 64'd0);
        check("abort_done", {63'd0, sa_if.done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); @(negedge clk);
            if (sa_if.done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        do_op(8'h01, 8'h01, 1'b0, 1'b0, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
